// File: rtl/uart_core_cfg.sv
// UART transceiver with configurable data width, parity and stop bits, RX error
// flags and an internal TX->RX loopback that only switches between frames.
module uart_core_cfg #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Loopback,
    input  logic       i_Tx_DV,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Active,
    output logic       o_Tx_Done,
    output logic       o_Tx_Serial,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Parity_Err,
    output logic       o_Rx_Frame_Err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [CNT_W-1:0] CNT_HALF     = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       BIT_LAST     = 3'(DATA_BITS - 1);
    localparam logic             STOP_LAST    = 1'(STOP_BITS - 1);
    localparam logic             PAR_ODD      = 1'(PARITY_ODD);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
    } rx_state_t;

    tx_state_t              tx_state_reg;
    logic [CNT_W-1:0]       tx_cnt_reg;
    logic [2:0]             tx_bit_idx_reg;
    logic                   tx_stop_idx_reg;
    logic [DATA_BITS-1:0]   tx_shift_reg;
    logic                   tx_parity_reg;

    rx_state_t              rx_state_reg;
    logic [CNT_W-1:0]       rx_cnt_reg;
    logic [2:0]             rx_bit_idx_reg;
    logic [DATA_BITS-1:0]   rx_shift_reg;
    logic                   rx_par_err_reg;
    logic                   rx_meta_reg;
    logic                   rx_sync_reg;
    logic                   loop_sel_reg;
    logic                   rx_line;
    logic [7:0]             rx_byte_ext;

    // ---------------- transmitter ----------------
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            tx_state_reg    <= TX_IDLE;
            tx_cnt_reg      <= '0;
            tx_bit_idx_reg  <= '0;
            tx_stop_idx_reg <= 1'b0;
            tx_shift_reg    <= '0;
            tx_parity_reg   <= 1'b0;
            o_Tx_Serial     <= 1'b1;
            o_Tx_Active     <= 1'b0;
            o_Tx_Done       <= 1'b0;
        end else begin
            o_Tx_Done <= 1'b0;
            case (tx_state_reg)
                TX_IDLE: begin
                    if (i_Tx_DV) begin
                        tx_shift_reg  <= i_Tx_Byte[DATA_BITS-1:0];
                        tx_parity_reg <= (^i_Tx_Byte[DATA_BITS-1:0]) ^ PAR_ODD;
                        tx_cnt_reg    <= '0;
                        o_Tx_Serial   <= 1'b0;
                        o_Tx_Active   <= 1'b1;
                        tx_state_reg  <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt_reg == CNT_LAST) begin
                        tx_cnt_reg     <= '0;
                        tx_bit_idx_reg <= '0;
                        o_Tx_Serial    <= tx_shift_reg[0];
                        tx_state_reg   <= TX_DATA;
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_reg == CNT_LAST) begin
                        tx_cnt_reg <= '0;
                        if (tx_bit_idx_reg == BIT_LAST) begin
                            tx_stop_idx_reg <= 1'b0;
                            if (PARITY_EN != 0) begin
                                o_Tx_Serial  <= tx_parity_reg;
                                tx_state_reg <= TX_PARITY;
                            end else begin
                                o_Tx_Serial  <= 1'b1;
                                tx_state_reg <= TX_STOP;
                            end
                        end else begin
                            tx_bit_idx_reg <= tx_bit_idx_reg + 1'b1;
                            tx_shift_reg   <= tx_shift_reg >> 1;
                            o_Tx_Serial    <= tx_shift_reg[1];
                        end
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg + 1'b1;
                    end
                end
                TX_PARITY: begin
                    if (tx_cnt_reg == CNT_LAST) begin
                        tx_cnt_reg   <= '0;
                        o_Tx_Serial  <= 1'b1;
                        tx_state_reg <= TX_STOP;
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_reg == CNT_LAST) begin
                        tx_cnt_reg <= '0;
                        if (tx_stop_idx_reg == STOP_LAST) begin
                            o_Tx_Active  <= 1'b0;
                            tx_state_reg <= TX_IDLE;
                        end else begin
                            tx_stop_idx_reg <= tx_stop_idx_reg + 1'b1;
                        end
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg + 1'b1;
                        // Done is registered, so raise it one cycle early to land on the final stop cycle.
                        if (tx_cnt_reg == CNT_PRE_LAST && tx_stop_idx_reg == STOP_LAST)
                            o_Tx_Done <= 1'b1;
                    end
                end
                default: tx_state_reg <= TX_IDLE;
            endcase
        end
    end

    // ---------------- receive path select and synchroniser ----------------
    assign rx_line = loop_sel_reg ? o_Tx_Serial : i_Rx_Serial;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rx_meta_reg  <= 1'b1;
            rx_sync_reg  <= 1'b1;
            loop_sel_reg <= 1'b0;
        end else begin
            rx_meta_reg <= rx_line;
            rx_sync_reg <= rx_meta_reg;
            if (tx_state_reg == TX_IDLE && rx_state_reg == RX_IDLE)
                loop_sel_reg <= i_Loopback;
        end
    end

    always_comb begin
        rx_byte_ext = '0;
        rx_byte_ext[DATA_BITS-1:0] = rx_shift_reg;
    end

    // ---------------- receiver ----------------
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rx_state_reg    <= RX_IDLE;
            rx_cnt_reg      <= '0;
            rx_bit_idx_reg  <= '0;
            rx_shift_reg    <= '0;
            rx_par_err_reg  <= 1'b0;
            o_Rx_DV         <= 1'b0;
            o_Rx_Byte       <= '0;
            o_Rx_Parity_Err <= 1'b0;
            o_Rx_Frame_Err  <= 1'b0;
        end else begin
            o_Rx_DV <= 1'b0;
            case (rx_state_reg)
                RX_IDLE: begin
                    if (!rx_sync_reg) begin
                        rx_cnt_reg   <= '0;
                        rx_state_reg <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt_reg == CNT_HALF) begin
                        rx_cnt_reg     <= '0;
                        rx_bit_idx_reg <= '0;
                        rx_state_reg   <= rx_sync_reg ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_reg == CNT_LAST) begin
                        rx_cnt_reg   <= '0;
                        rx_shift_reg <= {rx_sync_reg, rx_shift_reg[DATA_BITS-1:1]};
                        if (rx_bit_idx_reg == BIT_LAST)
                            rx_state_reg <= (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
                        else
                            rx_bit_idx_reg <= rx_bit_idx_reg + 1'b1;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + 1'b1;
                    end
                end
                RX_PARITY: begin
                    if (rx_cnt_reg == CNT_LAST) begin
                        rx_cnt_reg     <= '0;
                        rx_par_err_reg <= (^rx_shift_reg) ^ PAR_ODD ^ rx_sync_reg;
                        rx_state_reg   <= RX_STOP;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_reg == CNT_LAST) begin
                        rx_cnt_reg      <= '0;
                        o_Rx_DV         <= 1'b1;
                        o_Rx_Byte       <= rx_byte_ext;
                        o_Rx_Parity_Err <= rx_par_err_reg;
                        o_Rx_Frame_Err  <= ~rx_sync_reg;
                        // A low stop bit may be a break; wait for the line to recover first.
                        rx_state_reg    <= rx_sync_reg ? RX_IDLE : RX_WAIT_HIGH;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + 1'b1;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rx_sync_reg)
                        rx_state_reg <= RX_IDLE;
                end
                default: rx_state_reg <= RX_IDLE;
            endcase
        end
    end

endmodule
